// File: rtl/servo_pwm_bank_pkg.sv
// Shared definitions for the servo PWM bank and the position buffer writer.
package servo_pwm_bank_pkg;

    localparam int SERVO_POS_W = 8;

    localparam int DEF_TICK_DIV    = 50;
    localparam int DEF_MIN_TICKS   = 1000;
    localparam int DEF_STEP_TICKS  = 4;
    localparam int DEF_FRAME_TICKS = 20000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } servoState_t;

    // Bit offset of servo idx inside the packed position buffer.
    function automatic int servoSliceBase(input int idx);
        return idx * SERVO_POS_W;
    endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Control, position buffer and PWM outputs of the servo bank.
interface servo_pwm_bank_if
    import servo_pwm_bank_pkg::*;
#(
    parameter int NUM_SERVOS = 1
);
    logic                              enable;
    logic [SERVO_POS_W*NUM_SERVOS-1:0] pos_buffer;
    logic [NUM_SERVOS-1:0]             servo_out;
    logic                              frame_start;
    logic                              running;

    modport master (
        output enable,
        output pos_buffer,
        input  servo_out,
        input  frame_start,
        input  running
    );

    modport slave (
        input  enable,
        input  pos_buffer,
        output servo_out,
        output frame_start,
        output running
    );
endinterface

// File: rtl/servo_pwm_bank_tick_gen.sv
// Timing-tick prescaler: one-clk strobe every TICK_DIV clocks while not cleared.
module servo_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Next prescaler value: held at zero while cleared, wraps after the terminal count.
    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = !clear_i && (presc_q == PRESC_LAST);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of hobby-servo PWM outputs sharing one frame timer; positions are
// snapshotted at every frame start so mid-frame buffer writes never disturb
// a pulse already in progress.
module servo_pwm_bank
    import servo_pwm_bank_pkg::*;
#(
    parameter int NUM_SERVOS  = 1,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int STEP_TICKS  = DEF_STEP_TICKS,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_pwm_bank_if.slave  bus
);
    localparam int CNT_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int POS_BUS_W = SERVO_POS_W * NUM_SERVOS;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);

    servoState_t           state_q;
    servoState_t           state_d;
    logic [CNT_W-1:0]      frameCnt_q;
    logic [CNT_W-1:0]      frameCnt_d;
    logic [POS_BUS_W-1:0]  snap_q;
    logic [POS_BUS_W-1:0]  snap_d;
    logic [NUM_SERVOS-1:0] servoOut_q;
    logic [NUM_SERVOS-1:0] servoOut_d;
    logic [NUM_SERVOS-1:0] chanHigh;
    logic                  frameStart_q;
    logic                  tick;
    logic                  tickClear;
    logic                  frameWrap;
    logic                  startFrame;

    assign tickClear = (state_q == IDLE);

    servo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tickClear),
        .tick_o  (tick)
    );

    assign frameWrap = tick && (frameCnt_q == FRAME_LAST);

    // Frame sequencing: start from IDLE on enable, restart or stop at frame wrap.
    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        startFrame = 1'b0;
        case (state_q)
            IDLE: begin
                frameCnt_d = '0;
                if (bus.enable) begin
                    state_d    = RUN;
                    startFrame = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    if (frameWrap) begin
                        frameCnt_d = '0;
                        if (bus.enable) begin
                            startFrame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        frameCnt_d = frameCnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                frameCnt_d = '0;
            end
        endcase
    end

    assign snap_d = startFrame ? bus.pos_buffer : snap_q;

    // Per-channel compare of the upcoming frame count against the snapshotted width.
    for (genvar g = 0; g < NUM_SERVOS; g++) begin : gChan
        logic [31:0] widthTicks;
        assign widthTicks  = 32'(MIN_TICKS)
                           + 32'(snap_q[servoSliceBase(g) +: SERVO_POS_W]) * 32'(STEP_TICKS);
        assign chanHigh[g] = (32'(frameCnt_d) < widthTicks);
    end

    // Output selection: all lines rise on a frame start and drop when idling.
    always_comb begin
        servoOut_d = '0;
        if (startFrame) begin
            servoOut_d = '1;
        end else if (state_d == RUN) begin
            servoOut_d = chanHigh;
        end
    end

    // State, counter, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frameCnt_q   <= '0;
            snap_q       <= '0;
            servoOut_q   <= '0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frameCnt_q   <= frameCnt_d;
            snap_q       <= snap_d;
            servoOut_q   <= servoOut_d;
            frameStart_q <= startFrame;
        end
    end

    assign bus.servo_out   = servoOut_q;
    assign bus.frame_start = frameStart_q;
    assign bus.running     = (state_q == RUN);

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: clock-level reference model,
// table of position vectors with expected pulse lengths, hand-written
// corner sequences and a randomized soak.
module tb_servo_pwm_bank;
    import servo_pwm_bank_pkg::*;

    localparam int NSERV       = 3;
    localparam int TDIV        = 2;
    localparam int MINT        = 4;
    localparam int STEPT       = 1;
    localparam int FRAMET      = 300;
    localparam int FRAME_CLKS  = FRAMET * TDIV;
    localparam int WAIT_BOUND  = 2 * FRAME_CLKS + 100;

    typedef struct {
        logic [23:0] pos;
        int          expH0;
        int          expH1;
        int          expH2;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;
    bit modelOn  = 1'b0;

    servo_pwm_bank_if #(.NUM_SERVOS(NSERV)) bus ();

    servo_pwm_bank #(
        .NUM_SERVOS  (NSERV),
        .TICK_DIV    (TDIV),
        .MIN_TICKS   (MINT),
        .STEP_TICKS  (STEPT),
        .FRAME_TICKS (FRAMET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: frame position in clocks since the last frame start.
    bit          mRun   = 1'b0;
    bit          mStart = 1'b0;
    int          mPhase = 0;
    logic [23:0] mSnap  = '0;

    function automatic int pulseClks(input logic [7:0] p);
        return (MINT + int'(p) * STEPT) * TDIV;
    endfunction

    function automatic logic [NSERV-1:0] expServo();
        logic [NSERV-1:0] e;
        for (int i = 0; i < NSERV; i++) begin
            e[i] = mRun && (mPhase < pulseClks(mSnap[8*i +: 8]));
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRun   = 1'b0;
            mStart = 1'b0;
            mPhase = 0;
        end else begin
            mStart = 1'b0;
            if (mRun) begin
                mPhase++;
                if (mPhase == FRAME_CLKS) begin
                    mPhase = 0;
                    if (bus.enable) begin
                        mStart = 1'b1;
                        mSnap  = bus.pos_buffer;
                    end else begin
                        mRun = 1'b0;
                    end
                end
            end else if (bus.enable) begin
                mRun   = 1'b1;
                mPhase = 0;
                mStart = 1'b1;
                mSnap  = bus.pos_buffer;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model_servo_out", int'(bus.servo_out), int'(expServo()));
            checkOutput("model_frame_start", int'(bus.frame_start), int'(mStart));
            checkOutput("model_running", int'(bus.running), int'(mRun));
        end
    end

    task automatic applyStimulus(input logic [23:0] pos, input logic en);
        @(negedge clk);
        bus.pos_buffer = pos;
        bus.enable     = en;
    endtask

    task automatic waitFrameStart();
        bit found = 1'b0;
        for (int c = 0; c < WAIT_BOUND; c++) begin
            @(negedge clk);
            if (bus.frame_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("frame_start_timeout", 0, 1);
    endtask

    // Called at the negedge where frame_start is seen; ends on the next frame's first sample.
    task automatic measureFrame(input int updAt, input logic [7:0] updVal,
                                input int dropAt, input int raiseAt,
                                output int h0, output int h1, output int h2,
                                output int runLow);
        h0 = 0; h1 = 0; h2 = 0; runLow = 0;
        for (int s = 0; s < FRAME_CLKS; s++) begin
            if (bus.servo_out[0]) h0++;
            if (bus.servo_out[1]) h1++;
            if (bus.servo_out[2]) h2++;
            if (!bus.running) runLow++;
            if (s == updAt)   bus.pos_buffer[15:8] = updVal;
            if (s == dropAt)  bus.enable = 1'b0;
            if (s == raiseAt) bus.enable = 1'b1;
            @(negedge clk);
        end
    endtask

    vec_t vecs[4];

    initial begin
        int h0, h1, h2, rl, fsCount, pulseCount;

        vecs[0] = '{pos: 24'hFF_80_00, expH0: 8,   expH1: 264, expH2: 518};
        vecs[1] = '{pos: 24'h01_00_10, expH0: 40,  expH1: 8,   expH2: 10};
        vecs[2] = '{pos: 24'hFF_FF_FF, expH0: 518, expH1: 518, expH2: 518};
        vecs[3] = '{pos: 24'hC3_01_7F, expH0: 262, expH1: 10,  expH2: 398};

        bus.enable     = 1'b0;
        bus.pos_buffer = '0;
        #1 rst_n = 1'b0;
        modelOn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_servo_out", int'(bus.servo_out), 0);
        checkOutput("reset_frame_start", int'(bus.frame_start), 0);
        checkOutput("reset_running", int'(bus.running), 0);
        rst_n = 1'b1;

        // Idle with enable low, then start from IDLE.
        repeat (10) @(negedge clk);
        checkOutput("idle_running", int'(bus.running), 0);
        applyStimulus(24'hFF_80_00, 1'b1);
        @(negedge clk);
        checkOutput("start_frame_start", int'(bus.frame_start), 1);
        checkOutput("start_servo_out", int'(bus.servo_out), 7);
        checkOutput("start_running", int'(bus.running), 1);

        $display("[TB] basic widths");
        measureFrame(-1, 8'h00, -1, -1, h0, h1, h2, rl);
        checkOutput("basic_h0", h0, 8);
        checkOutput("basic_h1", h1, 264);
        checkOutput("basic_h2", h2, 518);
        checkOutput("basic_period", int'(bus.frame_start), 1);

        $display("[TB] mid-frame update");
        measureFrame(100, 8'h10, -1, -1, h0, h1, h2, rl);
        checkOutput("update_same_frame_h1", h1, 264);
        checkOutput("update_period", int'(bus.frame_start), 1);
        measureFrame(-1, 8'h00, -1, -1, h0, h1, h2, rl);
        checkOutput("update_next_frame_h1", h1, 40);

        $display("[TB] enable drop");
        measureFrame(-1, 8'h00, 50, -1, h0, h1, h2, rl);
        checkOutput("drop_h0", h0, 8);
        checkOutput("drop_h1", h1, 40);
        checkOutput("drop_h2", h2, 518);
        checkOutput("drop_running_in_frame_low", rl, 0);
        checkOutput("drop_running_end", int'(bus.running), 0);
        checkOutput("drop_frame_start_end", int'(bus.frame_start), 0);
        fsCount = 0; pulseCount = 0;
        for (int c = 0; c < 700; c++) begin
            if (bus.frame_start) fsCount++;
            if (bus.servo_out != '0) pulseCount++;
            @(negedge clk);
        end
        checkOutput("drop_no_frame_start", fsCount, 0);
        checkOutput("drop_no_pulse", pulseCount, 0);

        $display("[TB] enable re-assert before wrap");
        applyStimulus(24'hFF_80_00, 1'b1);
        waitFrameStart();
        measureFrame(-1, 8'h00, 50, 400, h0, h1, h2, rl);
        checkOutput("reassert_h1", h1, 264);
        checkOutput("reassert_running_low", rl, 0);
        checkOutput("reassert_frame_start", int'(bus.frame_start), 1);
        checkOutput("reassert_running", int'(bus.running), 1);

        $display("[TB] async reset mid-pulse");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_servo_out", int'(bus.servo_out), 0);
        checkOutput("areset_running", int'(bus.running), 0);
        checkOutput("areset_frame_start", int'(bus.frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("areset_restart_frame_start", int'(bus.frame_start), 1);
        checkOutput("areset_restart_servo_out", int'(bus.servo_out), 7);
        measureFrame(-1, 8'h00, -1, -1, h0, h1, h2, rl);
        checkOutput("areset_h0", h0, 8);
        checkOutput("areset_h1", h1, 264);
        checkOutput("areset_h2", h2, 518);

        $display("[TB] table vectors");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].pos, 1'b1);
            waitFrameStart();
            measureFrame(-1, 8'h00, -1, -1, h0, h1, h2, rl);
            checkOutput($sformatf("vec%0d_h0", v), h0, vecs[v].expH0);
            checkOutput($sformatf("vec%0d_h1", v), h1, vecs[v].expH1);
            checkOutput($sformatf("vec%0d_h2", v), h2, vecs[v].expH2);
            checkOutput($sformatf("vec%0d_period", v), int'(bus.frame_start), 1);
        end

        $display("[TB] randomized soak");
        for (int it = 0; it < 30; it++) begin
            int gap;
            int r;
            gap = $urandom_range(1, 900);
            repeat (gap) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 5) begin
                bus.pos_buffer = 24'($urandom);
            end else if (r < 8) begin
                bus.enable = ~bus.enable;
            end else if (r == 8) begin
                bus.enable = 1'b1;
            end else begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rand_areset_servo_out", int'(bus.servo_out), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        bus.enable = 1'b1;
        repeat (2 * FRAME_CLKS) @(negedge clk);

        modelOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
